// File: rtl/input_selector_pkg.sv
// Shared constants for the bit-addressable input port: geometry, read-mode
// encoding and the default debounce length.
package input_selector_pkg;

    localparam int WIDTH           = 8;
    localparam int ADDR_W          = 3;
    localparam int DEBOUNCE_CYCLES = 4;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/input_selector_if.sv
// Pin/read bus of the input port; slave is the port itself, master is the
// control-unit side that issues reads and consumes the selected bit.
interface input_selector_if
    import input_selector_pkg::*;
#(
    parameter int WIDTH  = input_selector_pkg::WIDTH,
    parameter int ADDR_W = input_selector_pkg::ADDR_W
);

    logic [WIDTH-1:0]  inPins;
    logic              read;
    logic              CE;
    logic              readDisable;
    logic              mode;
    logic [ADDR_W-1:0] addr;
    logic              data;
    logic              dataValid;
    logic [WIDTH-1:0]  edgeFlags;

    modport slave (
        input  inPins, read, CE, readDisable, mode, addr,
        output data, dataValid, edgeFlags
    );

    modport master (
        output inPins, read, CE, readDisable, mode, addr,
        input  data, dataValid, edgeFlags
    );

endinterface

// File: rtl/input_sync_bit.sv
// One input pin: 2-FF synchronizer, optional debounce filter (INPUT_DEBOUNCE_EN)
// and the filtered/delayed pair that yields a one-cycle rising-edge pulse.
module input_sync_bit
`ifdef INPUT_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = input_selector_pkg::DEBOUNCE_CYCLES
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic filt_o,
    output logic rise_o
);
    import input_selector_pkg::*;

    logic meta_q;
    logic sync_q;
    logic filt_q;
    logic filt_d;
    logic filtDly_q;

`ifdef INPUT_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive samples where the synchronized pin disagrees with the
    // filtered value; only a full run of DEBOUNCE_CYCLES lets the change through.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q != filt_q) begin
            if (cnt_q >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                filt_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        filt_d = sync_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            filt_q    <= 1'b0;
            filtDly_q <= 1'b0;
        end else begin
            meta_q    <= pin_i;
            sync_q    <= meta_q;
            filt_q    <= filt_d;
            filtDly_q <= filt_q;
        end
    end

    assign filt_o = filt_q;
    assign rise_o = filt_q & ~filtDly_q;

endmodule

// File: rtl/input_selector.sv
// Bit-addressable input port: per-pin filtering, sticky rising-edge flags and a
// registered single-bit read path. Debounce is enabled with INPUT_DEBOUNCE_EN.
module input_selector
#(
    parameter int WIDTH  = input_selector_pkg::WIDTH,
    parameter int ADDR_W = input_selector_pkg::ADDR_W
`ifdef INPUT_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = input_selector_pkg::DEBOUNCE_CYCLES
`endif
)
(
    input  logic             clk,
    input  logic             rst,
    input_selector_if.slave  bus
);
    import input_selector_pkg::*;

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] rise;

    for (genvar i = 0; i < WIDTH; i++) begin : gBit
        input_sync_bit
`ifdef INPUT_DEBOUNCE_EN
            #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
        uBit (
            .clk    (clk),
            .rst    (rst),
            .pin_i  (bus.inPins[i]),
            .filt_o (filt[i]),
            .rise_o (rise[i])
        );
    end

    logic             rdq;
    logic [WIDTH-1:0] clearMask;
    logic [WIDTH-1:0] flags_q;
    logic [WIDTH-1:0] flags_d;
    logic             data_q;
    logic             data_d;
    logic             valid_q;
    logic             valid_d;

    assign rdq = bus.read & bus.CE & ~bus.readDisable;

    // An edge read clears its flag, but a rise on the same bit in the same
    // cycle is OR-ed in afterwards so that edge is never lost.
    always_comb begin
        clearMask = '0;
        data_d    = data_q;
        valid_d   = 1'b0;
        if (rdq) begin
            valid_d = 1'b1;
            if (bus.mode == MODE_EDGE) begin
                data_d              = flags_q[bus.addr];
                clearMask[bus.addr] = 1'b1;
            end else begin
                data_d = filt[bus.addr];
            end
        end
        flags_d = (flags_q & ~clearMask) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.dataValid = valid_q;
    assign bus.edgeFlags = flags_q;

endmodule

// File: tb/tb_input_selector.sv
// Self-checking bench for input_selector; expected read data is queued when a
// read is issued and popped when the DUT answers. Honours INPUT_DEBOUNCE_EN.
module tb_input_selector;
    import input_selector_pkg::*;

`ifdef INPUT_DEBOUNCE_EN
    localparam int LAT = 2 + DEBOUNCE_CYCLES;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pins;
    logic       expQ[$];
    logic       exp;
    int         testsRun    = 0;
    int         testsFailed = 0;

    input_selector_if bus ();

    input_selector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic driveRead(input logic m, input int a);
        bus.read        = 1'b1;
        bus.CE          = 1'b1;
        bus.readDisable = 1'b0;
        bus.mode        = m;
        bus.addr        = ADDR_W'(a);
    endtask

    task automatic idle();
        bus.read = 1'b0;
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        pins            = 8'hFF;
        bus.inPins      = pins;
        driveRead(MODE_LEVEL, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            testsRun += 3;
            if (bus.data !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_data cycle %0d: got %b, required 0", c, bus.data);
            end
            if (bus.dataValid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_valid cycle %0d: got %b, required 0", c, bus.dataValid);
            end
            if (bus.edgeFlags !== 8'h00) begin
                testsFailed++;
                $display("[TB] FAIL reset_flags cycle %0d: got %h, required 00", c, bus.edgeFlags);
            end
        end
        rst = 1'b0;
        idle();
        for (int k = 1; k <= LAT; k++) begin
            tick();
            testsRun += 2;
            if (bus.edgeFlags !== 8'h00) begin
                testsFailed++;
                $display("[TB] FAIL post_reset_flags cycle %0d: got %h, required 00", k, bus.edgeFlags);
            end
            if (bus.dataValid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL post_reset_valid cycle %0d: got %b, required 0", k, bus.dataValid);
            end
        end
        tick();
        testsRun++;
        if (bus.edgeFlags !== 8'hFF) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_flags: got %h, required ff", bus.edgeFlags);
        end
    endtask

    task automatic test_level_read();
        int addrs[4] = '{0, 1, 2, 5};
        pins       = 8'hA5;
        bus.inPins = pins;
        repeat (LAT + 1) tick();
        for (int i = 0; i < 4; i++) begin
            driveRead(MODE_LEVEL, addrs[i]);
            expQ.push_back(pins[addrs[i]]);
            tick();
            exp = expQ.pop_front();
            testsRun++;
            if (bus.dataValid !== 1'b1 || bus.data !== exp) begin
                testsFailed++;
                $display("[TB] FAIL level_read addr %0d: valid=%b data=%b, required valid=1 data=%b",
                         addrs[i], bus.dataValid, bus.data, exp);
            end
        end
        idle();
        tick();
        testsRun++;
        if (bus.dataValid !== 1'b0 || bus.data !== exp || bus.edgeFlags !== 8'hFF) begin
            testsFailed++;
            $display("[TB] FAIL level_idle_hold: valid=%b data=%b flags=%h, required valid=0 data=%b flags=ff",
                     bus.dataValid, bus.data, bus.edgeFlags, exp);
        end
    endtask

    task automatic test_qualification();
        for (int v = 0; v < 4; v++) begin
            driveRead((v >= 2) ? MODE_EDGE : MODE_LEVEL, 1);
            if (v % 2 == 0) bus.CE = 1'b0;
            else            bus.readDisable = 1'b1;
            tick();
            testsRun++;
            if (bus.dataValid !== 1'b0 || bus.data !== 1'b1 || bus.edgeFlags[1] !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL qualification variant %0d: valid=%b data=%b flag1=%b, required valid=0 data=1 flag1=1",
                         v, bus.dataValid, bus.data, bus.edgeFlags[1]);
            end
        end
        bus.readDisable = 1'b0;
        bus.CE          = 1'b1;
        idle();
    endtask

    task automatic test_edge_clear();
        driveRead(MODE_EDGE, 3);
        expQ.push_back(1'b1);
        tick();
        exp = expQ.pop_front();
        testsRun++;
        if (bus.dataValid !== 1'b1 || bus.data !== exp || bus.edgeFlags !== 8'hF7) begin
            testsFailed++;
            $display("[TB] FAIL edge_clear_initial: valid=%b data=%b flags=%h, required valid=1 data=%b flags=f7",
                     bus.dataValid, bus.data, bus.edgeFlags, exp);
        end
        idle();
        pins[3]    = 1'b1;
        bus.inPins = pins;
        repeat (LAT) tick();
        testsRun++;
        if (bus.edgeFlags[3] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL edge_rise_early: flag3=%b, required 0", bus.edgeFlags[3]);
        end
        tick();
        testsRun++;
        if (bus.edgeFlags[3] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL edge_rise_set: flag3=%b, required 1", bus.edgeFlags[3]);
        end
        for (int r = 0; r < 2; r++) begin
            driveRead(MODE_EDGE, 3);
            expQ.push_back((r == 0) ? 1'b1 : 1'b0);
            tick();
            exp = expQ.pop_front();
            testsRun++;
            if (bus.dataValid !== 1'b1 || bus.data !== exp || bus.edgeFlags[3] !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL edge_read %0d: valid=%b data=%b flag3=%b, required valid=1 data=%b flag3=0",
                         r, bus.dataValid, bus.data, bus.edgeFlags[3], exp);
            end
        end
        idle();
        pins[3]    = 1'b0;
        bus.inPins = pins;
        repeat (LAT + 3) tick();
        testsRun++;
        if (bus.edgeFlags[3] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL falling_edge_flag: flag3=%b, required 0", bus.edgeFlags[3]);
        end
    endtask

    task automatic test_set_wins();
        driveRead(MODE_EDGE, 6);
        expQ.push_back(1'b1);
        tick();
        exp = expQ.pop_front();
        testsRun++;
        if (bus.dataValid !== 1'b1 || bus.data !== exp || bus.edgeFlags[6] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL set_wins_prep: valid=%b data=%b flag6=%b, required valid=1 data=%b flag6=0",
                     bus.dataValid, bus.data, bus.edgeFlags[6], exp);
        end
        idle();
        pins[6]    = 1'b1;
        bus.inPins = pins;
        repeat (LAT) tick();
        driveRead(MODE_EDGE, 6);
        expQ.push_back(1'b0);
        tick();
        exp = expQ.pop_front();
        testsRun++;
        if (bus.dataValid !== 1'b1 || bus.data !== exp || bus.edgeFlags[6] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL set_wins_collision: valid=%b data=%b flag6=%b, required valid=1 data=%b flag6=1",
                     bus.dataValid, bus.data, bus.edgeFlags[6], exp);
        end
        driveRead(MODE_EDGE, 6);
        expQ.push_back(1'b1);
        tick();
        exp = expQ.pop_front();
        testsRun++;
        if (bus.dataValid !== 1'b1 || bus.data !== exp || bus.edgeFlags[6] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL set_wins_followup: valid=%b data=%b flag6=%b, required valid=1 data=%b flag6=0",
                     bus.dataValid, bus.data, bus.edgeFlags[6], exp);
        end
        idle();
    endtask

    task automatic test_glitch();
        driveRead(MODE_EDGE, 1);
        expQ.push_back(1'b1);
        tick();
        exp = expQ.pop_front();
        testsRun++;
        if (bus.dataValid !== 1'b1 || bus.data !== exp || bus.edgeFlags[1] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL glitch_prep: valid=%b data=%b flag1=%b, required valid=1 data=%b flag1=0",
                     bus.dataValid, bus.data, bus.edgeFlags[1], exp);
        end
        idle();
`ifdef INPUT_DEBOUNCE_EN
        pins[1]    = 1'b1;
        bus.inPins = pins;
        repeat (DEBOUNCE_CYCLES - 1) tick();
        pins[1]    = 1'b0;
        bus.inPins = pins;
        repeat (LAT + 4) tick();
        testsRun++;
        if (bus.edgeFlags[1] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL debounce_glitch_flag: flag1=%b, required 0", bus.edgeFlags[1]);
        end
        driveRead(MODE_LEVEL, 1);
        expQ.push_back(1'b0);
        tick();
        exp = expQ.pop_front();
        testsRun++;
        if (bus.dataValid !== 1'b1 || bus.data !== exp) begin
            testsFailed++;
            $display("[TB] FAIL debounce_glitch_filt: valid=%b data=%b, required valid=1 data=%b",
                     bus.dataValid, bus.data, exp);
        end
        idle();
        pins[1]    = 1'b1;
        bus.inPins = pins;
        for (int k = 1; k <= DEBOUNCE_CYCLES + 2; k++) begin
            tick();
            testsRun++;
            if (bus.edgeFlags[1] !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL debounce_pulse_early cycle %0d: flag1=%b, required 0", k, bus.edgeFlags[1]);
            end
        end
        pins[1]    = 1'b0;
        bus.inPins = pins;
        tick();
        testsRun++;
        if (bus.edgeFlags[1] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL debounce_pulse_set: flag1=%b, required 1", bus.edgeFlags[1]);
        end
`else
        pins[1]    = 1'b1;
        bus.inPins = pins;
        tick();
        pins[1]    = 1'b0;
        bus.inPins = pins;
        repeat (LAT - 1) tick();
        testsRun++;
        if (bus.edgeFlags[1] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL short_pulse_early: flag1=%b, required 0", bus.edgeFlags[1]);
        end
        tick();
        testsRun++;
        if (bus.edgeFlags[1] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL short_pulse_set: flag1=%b, required 1", bus.edgeFlags[1]);
        end
`endif
    endtask

    initial begin
        bus.read        = 1'b0;
        bus.CE          = 1'b0;
        bus.readDisable = 1'b0;
        bus.mode        = MODE_LEVEL;
        bus.addr        = '0;
        test_reset();
        test_level_read();
        test_qualification();
        test_edge_clear();
        test_set_wins();
        test_glitch();
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/input_selector.md
Name: input_selector

Overview:
- Bit-addressable input port for the processor. It is the read-side counterpart of the bit-addressable output latch.
- Samples 8 external input pins through a synchronizer and an optional debounce filter.
- Keeps per-bit sticky rising-edge flags.
- Returns one selected bit to the datapath, one cycle after a qualified read strobe.

Parameters:
- WIDTH, 8, number of input pins.
- ADDR_W, 3, bit-select address width (2^ADDR_W = WIDTH).
- DEBOUNCE_CYCLES, 4, consecutive stable samples required before the filtered value changes (used only with INPUT_DEBOUNCE_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- inPins  input  WIDTH  asynchronous external inputs.
- read  input  1  read strobe from the control unit.
- CE  input  1  chip enable from the address decoder.
- readDisable  input  1  suppresses reads (bus owned elsewhere).
- mode  input  1  0 = level read, 1 = edge-flag read (read-to-clear).
- addr  input  ADDR_W  bit select.
- data  output  1  registered selected bit.
- dataValid  output  1  one-cycle pulse, asserted when data is updated.
- edgeFlags  output  WIDTH  current sticky rising-edge flags (status/debug).

Behaviour:
- Reset: sync stages, filtered values, edgeFlags, data and dataValid are all 0. Debounce counters are 0.
- Reset takes priority over every other event in the same cycle. A read issued in a reset cycle is dropped and dataValid stays 0 on the next cycle.
- Synchronizer: two flip-flops per bit.
  - The sync output equals inPins delayed by 2 cycles.
  - No combinational path from inPins to any output.
- Filtered value without debounce:
  - filt[i] = sync[i], registered once.
  - A pin change is visible in filt 3 cycles after inPins changes.
- Rising edge detection:
  - rise[i] = filt[i] & ~filt_d[i], where filt_d is filt delayed one cycle.
  - rise[i] sets edgeFlags[i] on the next clock.
- Qualified read: rdq = read & CE & ~readDisable.
- Read, level mode (mode = 0):
  - Cycle after rdq: data = filt[addr] as sampled in the rdq cycle; dataValid = 1.
  - edgeFlags are unchanged.
- Read, edge mode (mode = 1):
  - Cycle after rdq: data = edgeFlags[addr] as sampled in the rdq cycle; dataValid = 1.
  - edgeFlags[addr] is cleared on the same clock edge.
- Simultaneous set and clear on the same bit: set wins, so the flag stays 1 and no edge is lost. Other bits are unaffected by a clear.
- Without rdq:
  - dataValid = 0.
  - data holds its last value.
  - edgeFlags only accumulate.
- Back-to-back reads: rdq may be asserted every cycle, and each one produces its own dataValid pulse one cycle later.
- addr is used only in the rdq cycle. With the default parameters all addr values are legal.
- Falling edges never set a flag.

Optional Feature:
INPUT_DEBOUNCE_EN:
- Defined:
  - Each bit has a saturating counter of width clog2(DEBOUNCE_CYCLES)+1.
  - When sync[i] differs from filt[i], the counter increments. When they are equal, it resets to 0.
  - When the counter reaches DEBOUNCE_CYCLES - 1 while they still differ, filt[i] takes sync[i] and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES sync samples never changes filt and never sets a flag.
  - Pin-to-filt latency = 2 + DEBOUNCE_CYCLES cycles.
- Not defined: filt = registered sync, as described in Behaviour; no counters are synthesized.

Decomposition:
- Package input_selector_pkg holds:
  - WIDTH and ADDR_W constants.
  - mode encoding constants MODE_LEVEL = 1'b0 and MODE_EDGE = 1'b1.
  - the default DEBOUNCE_CYCLES.
- One sub-module, input_sync_bit, instantiated WIDTH times. It contains:
  - the 2-FF synchronizer;
  - the optional debounce counter;
  - the filt/filt_d registers.
  - It outputs filt and rise.
- Top level holds edgeFlags, read qualification and the output registers.

Test Plan:
- Reset: drive inPins = 8'hFF and hold rst for 2 cycles -> data = 0, dataValid = 0 and edgeFlags = 8'h00 throughout. Release rst: edgeFlags = 8'hFF 4 cycles later (no debounce).
- Level read: inPins = 8'hA5, wait 4 cycles, pulse rdq with mode = 0 for addr = 0, 1, 2, 5 on consecutive cycles -> data = 1, 0, 1, 1 on the following cycles, with 4 consecutive dataValid pulses.
- Qualification: read = 1 with CE = 0, or with readDisable = 1 -> no dataValid and data unchanged. Repeat with mode = 1 on a set flag -> the flag is not cleared.
- Edge read-to-clear: set inPins[3] = 0, then raise it to 1 and wait 4 cycles -> edgeFlags[3] = 1. Edge read at addr = 3 -> data = 1 and edgeFlags[3] = 0. A second read -> data = 0.
- Set-wins collision: time a rising edge on bit 6 so that rise[6] is high in the same cycle as an edge read of addr = 6 -> that read returns the old flag value and edgeFlags[6] = 1 afterwards.
- Debounce, with INPUT_DEBOUNCE_EN and DEBOUNCE_CYCLES = 4:
  - A 3-cycle high glitch on inPins[0] -> no flag set and filt unchanged.
  - A 6-cycle high pulse -> edgeFlags[0] = 1, exactly 7 cycles after the pulse starts.
